// File: rtl/alu_op_dispatch_if.sv
// -----------------------------------------------------------------------------
// alu_op_dispatch_if
//   Bundles every non-clock/reset signal of the ALU operation dispatcher.
//
//   Request side : req_valid, req_ready, req_op[2:0], req_a[N-1:0], req_b[N-1:0]
//   Unit side    : unit_en[6:0], opd_a[N-1:0], opd_b[N-1:0], unit_done[6:0]
//   Response side: sel_out[2:0], rsp_valid, rsp_ready, rsp_err
//
//   slave  : the dispatcher itself
//   master : the requester / functional units / response consumer
// -----------------------------------------------------------------------------
interface alu_op_dispatch_if #(
    parameter int N = 4
);
    logic           req_valid;
    logic           req_ready;
    logic [2:0]     req_op;
    logic [N-1:0]   req_a;
    logic [N-1:0]   req_b;
    logic [6:0]     unit_en;
    logic [N-1:0]   opd_a;
    logic [N-1:0]   opd_b;
    logic [6:0]     unit_done;
    logic [2:0]     sel_out;
    logic           rsp_valid;
    logic           rsp_ready;
    logic           rsp_err;

    modport slave (
        input  req_valid, req_op, req_a, req_b, unit_done, rsp_ready,
        output req_ready, unit_en, opd_a, opd_b, sel_out, rsp_valid, rsp_err
    );

    modport master (
        output req_valid, req_op, req_a, req_b, unit_done, rsp_ready,
        input  req_ready, unit_en, opd_a, opd_b, sel_out, rsp_valid, rsp_err
    );
endinterface

// File: rtl/alu_op_dispatch.sv
// -----------------------------------------------------------------------------
// alu_op_dispatch
//   Issue-side counterpart of the ALU result multiplexer. Accepts one request
//   at a time, pulses a one-hot start to one of seven functional units, waits
//   for that unit's completion (bounded by TIMEOUT cycles) and then presents a
//   response with the result-mux select.
//
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous active-high reset
//     bus  - alu_op_dispatch_if.slave (request, unit and response signals)
//
//   Parameters:
//     N       - operand width
//     TIMEOUT - max WAIT cycles before an error response (1..255)
// -----------------------------------------------------------------------------
module alu_op_dispatch #(
    parameter int N       = 4,
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rst,
    alu_op_dispatch_if.slave   bus
);
    localparam int          CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [2:0]  OP_ILLEGAL = 3'b111;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q,    op_d;
    logic [N-1:0]       opd_a_q, opd_a_d;
    logic [N-1:0]       opd_b_q, opd_b_d;
    logic               err_q,   err_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [6:0]         op_onehot;
    logic               done_hit;

    // One-hot decode of the captured op; the illegal code decodes to zero so
    // it can never start a unit nor be matched against unit_done.
    always_comb begin
        op_onehot = '0;
        if (op_q != OP_ILLEGAL) begin
            op_onehot[op_q] = 1'b1;
        end
    end

    // Only the active unit's completion bit is observed.
    assign done_hit = |(bus.unit_done & op_onehot);

    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        opd_a_d       = opd_a_q;
        opd_b_d       = opd_b_q;
        err_d         = err_q;
        cnt_d         = cnt_q;
        bus.req_ready = 1'b0;
        bus.unit_en   = '0;
        bus.rsp_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    op_d    = bus.req_op;
                    opd_a_d = bus.req_a;
                    opd_b_d = bus.req_b;
                    cnt_d   = '0;
                    if (bus.req_op == OP_ILLEGAL) begin
                        // Illegal op skips the units entirely.
                        state_d = RESP;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        err_d   = 1'b0;
                    end
                end
            end

            ISSUE: begin
                // unit_done is deliberately not looked at here.
                bus.unit_en = op_onehot;
                state_d     = WAIT;
            end

            WAIT: begin
                if (done_hit) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    err_d   = 1'b0;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            opd_a_q <= '0;
            opd_b_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            opd_a_q <= opd_a_d;
            opd_b_q <= opd_b_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // sel_out and operands persist after the response so the result mux keeps
    // routing the finished unit until the next acceptance.
    assign bus.sel_out = op_q;
    assign bus.opd_a   = opd_a_q;
    assign bus.opd_b   = opd_b_q;
    assign bus.rsp_err = err_q;

endmodule

// File: tb/tb_alu_op_dispatch.sv
module tb_alu_op_dispatch;
    localparam int N       = 4;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    alu_op_dispatch_if #(.N(N)) bus ();

    alu_op_dispatch #(.N(N), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string ctx);
        check({ctx, "_req_ready"}, 32'(bus.req_ready), 32'h1);
        check({ctx, "_unit_en"},   32'(bus.unit_en),   32'h0);
        check({ctx, "_opd_a"},     32'(bus.opd_a),     32'h0);
        check({ctx, "_opd_b"},     32'(bus.opd_b),     32'h0);
        check({ctx, "_sel_out"},   32'(bus.sel_out),   32'h0);
        check({ctx, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
        check({ctx, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
    endtask

    // Issues one request from IDLE and leaves the DUT in RESP (no handshake).
    // exp_en = expected one-hot start (0 for the illegal op);
    // done_at = WAIT cycle (1-based) in which unit_done[op] rises, 0 = never.
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [6:0] exp_en, input int done_at, input logic exp_err);
        check("idle_req_ready", 32'(bus.req_ready), 32'h1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        tick();
        bus.req_valid = 1'b0;
        check("acc_sel_out",   32'(bus.sel_out),   32'(op));
        check("acc_opd_a",     32'(bus.opd_a),     32'(a));
        check("acc_opd_b",     32'(bus.opd_b),     32'(b));
        check("acc_req_ready", 32'(bus.req_ready), 32'h0);
        check("acc_unit_en",   32'(bus.unit_en),   32'(exp_en));
        if (exp_en == 7'b0) begin
            check("illegal_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("illegal_rsp_err",   32'(bus.rsp_err),   32'(exp_err));
            return;
        end
        check("issue_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        // Completion during ISSUE must be ignored.
        if (done_at != 1) bus.unit_done = exp_en;
        tick();
        for (int k = 1; k <= TIMEOUT; k++) begin
            check("wait_unit_en",   32'(bus.unit_en),   32'h0);
            check("wait_rsp_valid", 32'(bus.rsp_valid), 32'h0);
            check("wait_req_ready", 32'(bus.req_ready), 32'h0);
            if (k == done_at) bus.unit_done = exp_en;
            else              bus.unit_done = (k % 2 == 1) ? ~exp_en : 7'b0;
            tick();
            if (k == done_at) break;
        end
        bus.unit_done = 7'b0;
        check("resp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("resp_rsp_err",   32'(bus.rsp_err),   32'(exp_err));
        check("resp_sel_out",   32'(bus.sel_out),   32'(op));
        check("resp_opd_a",     32'(bus.opd_a),     32'(a));
        check("resp_unit_en",   32'(bus.unit_en),   32'h0);
        check("resp_req_ready", 32'(bus.req_ready), 32'h0);
    endtask

    task automatic finish_rsp();
        check("pre_hs_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("post_hs_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("post_hs_rsp_err",   32'(bus.rsp_err),   32'h0);
        check("post_hs_req_ready", 32'(bus.req_ready), 32'h1);
        check("post_hs_unit_en",   32'(bus.unit_en),   32'h0);
    endtask

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.unit_done = 7'b0;
        bus.rsp_ready = 1'b0;

        // Reset state
        tick();
        tick();
        check_reset("reset");
        rst = 1'b0;
        tick();

        // Basic op 2, completion on the first WAIT cycle
        run_op(3'b010, 4'h5, 4'h3, 7'b0000100, 1, 1'b0);
        finish_rsp();

        // Illegal op: immediate error response, no start pulse
        run_op(3'b111, 4'hA, 4'hC, 7'b0000000, 0, 1'b1);
        finish_rsp();

        // Timeout on op 5 with unrelated done bits toggling
        run_op(3'b101, 4'h6, 4'h9, 7'b0100000, 0, 1'b1);

        // Backpressure: response held, new request ignored
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = 1'b1;
            bus.req_op    = 3'b001;
            bus.req_a     = 4'hF;
            bus.req_b     = 4'hE;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'h1);
            check("bp_rsp_err",   32'(bus.rsp_err),   32'h1);
            check("bp_sel_out",   32'(bus.sel_out),   32'h5);
            check("bp_opd_a",     32'(bus.opd_a),     32'h6);
            check("bp_req_ready", 32'(bus.req_ready), 32'h0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        check("bp_idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("bp_idle_req_ready", 32'(bus.req_ready), 32'h1);
        check("bp_idle_sel_out",   32'(bus.sel_out),   32'h5);
        check("bp_idle_opd_a",     32'(bus.opd_a),     32'h6);
        tick();
        bus.req_valid = 1'b0;
        check("bp_next_sel_out", 32'(bus.sel_out), 32'h1);
        check("bp_next_opd_a",   32'(bus.opd_a),   32'hF);
        check("bp_next_unit_en", 32'(bus.unit_en), 32'b0000010);
        tick();
        bus.unit_done = 7'b0000010;
        tick();
        bus.unit_done = 7'b0;
        check("bp_next_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("bp_next_rsp_err",   32'(bus.rsp_err),   32'h0);
        finish_rsp();

        // Back-to-back ops 0 then 6, completion in the 4th WAIT cycle
        run_op(3'b000, 4'h1, 4'h2, 7'b0000001, 4, 1'b0);
        finish_rsp();
        check("b2b_idle_sel_out", 32'(bus.sel_out), 32'h0);
        run_op(3'b110, 4'h3, 4'h4, 7'b1000000, 4, 1'b0);
        finish_rsp();

        // Reset during WAIT
        bus.req_valid = 1'b1;
        bus.req_op    = 3'b011;
        bus.req_a     = 4'h7;
        bus.req_b     = 4'h8;
        tick();
        bus.req_valid = 1'b0;
        tick();
        check("pre_rst_wait_opd_a", 32'(bus.opd_a), 32'h7);
        rst = 1'b1;
        #1;
        check_reset("rst_wait");
        tick();
        rst = 1'b0;

        // Reset during RESP
        run_op(3'b111, 4'hB, 4'hD, 7'b0000000, 0, 1'b1);
        rst = 1'b1;
        #1;
        check_reset("rst_resp");
        tick();
        rst = 1'b0;

        // First request after reset behaves like the basic case
        run_op(3'b010, 4'h5, 4'h3, 7'b0000100, 1, 1'b0);
        finish_rsp();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
